ll_search_scheduler: RTL and testbench
======================================

// Module: ll_search_scheduler
// PURPOSE
//  Shares one linked-list node memory between NUM_REQ search requesters. Grants one request
//  at a time, round-robin, then walks the list from start_node until one of: target found,
//  null link, or hop limit reached. Returns the result over a valid/ready response channel.
//  Sits between requester agents and the node RAM (sync read, 1-cycle latency).
// PARAMETERS
//  ADDR_WIDTH  4              node address width; address 0 is NULL (end of list)
//  DATA_WIDTH  4              node payload width; node word = {data, next_addr}
//  NUM_REQ     4              number of requesters (>=2)
//  MAX_HOPS    2**ADDR_WIDTH  memory reads allowed per search before timeout (cycle guard)
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous reset, active-high
//  req_valid    in   NUM_REQ              per-requester search request
//  req_ready    out  NUM_REQ              one-hot grant; request accepted when valid&ready
//  req_start    in   NUM_REQ*ADDR_WIDTH   start node per requester; slice i = requester i
//  req_target   in   NUM_REQ*ADDR_WIDTH   node address to find per requester
//  mem_rd_en    out  1                    node RAM read strobe
//  mem_rd_addr  out  ADDR_WIDTH           node RAM read address
//  mem_rd_data  in   ADDR_WIDTH+DATA_WIDTH  node word; valid the cycle after mem_rd_en
//  rsp_valid    out  1                    result valid; held until rsp_ready
//  rsp_ready    in   1                    consumer accepts result
//  rsp_id       out  $clog2(NUM_REQ)      requester index of the result
//  rsp_found    out  1                    target reached
//  rsp_timeout  out  1                    MAX_HOPS reached without match/NULL
//  rsp_hops     out  $clog2(MAX_HOPS+1)   number of memory reads performed
//  busy         out  1                    state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, every output 0, curr/hops cleared. Reset mid-search
//    aborts it with no response. Read data arriving the cycle after reset is ignored.
//  - IDLE: req_ready = round-robin one-hot over req_valid, starting at pointer; 0 if none valid.
//    On accept, latch id/start/target, set hops=0, go CHECK, set pointer=(id+1)%NUM_REQ.
//    req_ready is 0 in every state except IDLE. req_ready must not depend on rsp_ready.
//  - CHECK (priority order):
//    - curr==0 -> RESP found=0.
//    - curr==target -> RESP found=1.
//    - hops==MAX_HOPS -> RESP timeout=1.
//    - otherwise: mem_rd_en=1, mem_rd_addr=curr, hops++, go WAIT.
//    Consequence: target==0 never matches.
//  - WAIT: curr <= mem_rd_data[ADDR_WIDTH-1:0]; data field ignored; go CHECK.
//  - RESP: rsp_* registered and stable while rsp_valid=1 && rsp_ready=0. On handshake go to
//    IDLE. A new grant is possible the cycle after that.
//  - Latency: accept at cycle T -> rsp_valid at T+2+2*hops. At most 1 RAM read per 2 cycles.
//  - mem_rd_addr = 0 whenever mem_rd_en=0.
// CONFIGURATION
//  LL_SCHED_STATS_EN defined:
//    - Adds inputs: stat_clr.
//    - Adds outputs: stat_searches, stat_found, stat_timeouts (16-bit each).
//    - Counters saturate. Each increments on a response handshake.
//    - stat_clr zeroes all three counters; stat_clr wins over a same-cycle increment.
//    - Reset clears all three counters.
//  LL_SCHED_STATS_EN undefined: no stats ports and no counter logic. Base behaviour is identical.
// STRUCTURE
//  - ll_pkg contents:
//    - NULL_ADDR = '0.
//    - node_t packed struct {data, next}.
//    - sched_state_e enum {IDLE, CHECK, WAIT, RESP}.
//  - Sub-module ll_rr_arbiter #(NUM_REQ): inputs req, ptr -> outputs one-hot gnt, gnt_id.
//    Purely combinational.
// TESTING (ADDR_WIDTH=4, NUM_REQ=4; RAM: 3->5, 5->9, 9->0 unless noted)
//  1. req0 start=3 target=9
//     -> reads addr 3 then 5; rsp id=0 found=1 timeout=0 hops=2, rsp_valid at T+6.
//  2. req2 start=3 target=7
//     -> reads 3,5,9; found=0 timeout=0 hops=3 at T+8.
//  3. RAM 3->5, 5->3; start=3 target=7
//     -> 16 reads; found=0 timeout=1 hops=16.
//  4. All 4 valid, start=target=3; responses id 0,1,2,3 in order.
//     Then req1 and req3 valid together -> grant 1 then 3.
//  5. start=0 -> no mem_rd_en; found=0 hops=0 at T+2.
//     Hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0.
//  6. rst=1 during WAIT of test 1 -> next cycle busy=0, rsp_valid=0; no response follows.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared types for the linked-list search scheduler: node word layout, FSM states, NULL address.
// The node_t widths match the scheduler's default address and payload widths.
package ll_pkg;
  localparam int LL_ADDR_W = 4;
  localparam int LL_DATA_W = 4;

  localparam logic [LL_ADDR_W-1:0] NULL_ADDR = '0;

  typedef struct packed {
    logic [LL_DATA_W-1:0] data;
    logic [LL_ADDR_W-1:0] next;
  } node_t;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, RESP} sched_state_e;
endpackage

// File: rtl/ll_rr_arbiter.sv
// Round-robin one-hot arbiter: the first asserted request at or after ptr wins.
// Purely combinational, no state; ptr is owned by the caller.
module ll_rr_arbiter
  import ll_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  logic            hit;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end
endmodule

// File: rtl/ll_search_scheduler.sv
// Shares one node RAM among NUM_REQ searchers; result at accept+2+2*hops, held until rsp_ready.
// Only one search in flight; req_ready is low outside IDLE. LL_SCHED_STATS_EN adds response counters.
module ll_search_scheduler
  import ll_pkg::*;
#(
  parameter int ADDR_WIDTH = LL_ADDR_W,
  parameter int DATA_WIDTH = LL_DATA_W,
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOPS   = 2**ADDR_WIDTH,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int HOP_W = $clog2(MAX_HOPS+1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_target,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_rd_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic                            rsp_found,
  output logic                            rsp_timeout,
  output logic [HOP_W-1:0]                rsp_hops,
  output logic                            busy
`ifdef LL_SCHED_STATS_EN
  ,
  input  logic                            stat_clr,
  output logic [15:0]                     stat_searches,
  output logic [15:0]                     stat_found,
  output logic [15:0]                     stat_timeouts
`endif
);
  localparam logic [ADDR_WIDTH-1:0] NULL_A = ADDR_WIDTH'(NULL_ADDR);

  sched_state_e          state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d;
  logic [ADDR_WIDTH-1:0] curr_q, curr_d, target_q, target_d;
  logic [HOP_W-1:0]      hops_q, hops_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_found_q, rsp_found_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [HOP_W-1:0]      rsp_hops_q, rsp_hops_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_id;
  logic                  unused_payload;

  // Only the next-link field of the node word steers the walk.
  assign unused_payload = ^mem_rd_data[ADDR_WIDTH+DATA_WIDTH-1:ADDR_WIDTH];

  ll_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    curr_d        = curr_q;
    target_d      = target_q;
    hops_d        = hops_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_found_d   = rsp_found_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_hops_d    = rsp_hops_q;
    req_ready     = '0;
    mem_rd_en     = 1'b0;
    mem_rd_addr   = '0;
    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          id_d     = gnt_id;
          curr_d   = req_start[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
          target_d = req_target[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
          hops_d   = '0;
          ptr_d    = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        // NULL beats a match, so a target of NULL never reports found.
        if (curr_q == NULL_A || curr_q == target_q || hops_q == HOP_W'(MAX_HOPS)) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_id_d      = id_q;
          rsp_hops_d    = hops_q;
          rsp_found_d   = (curr_q != NULL_A) && (curr_q == target_q);
          rsp_timeout_d = (curr_q != NULL_A) && (curr_q != target_q);
        end else begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = curr_q;
          hops_d      = hops_q + HOP_W'(1);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        curr_d  = mem_rd_data[ADDR_WIDTH-1:0];
        state_d = CHECK;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      curr_q        <= '0;
      target_q      <= '0;
      hops_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_found_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_hops_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      curr_q        <= curr_d;
      target_q      <= target_d;
      hops_q        <= hops_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_found_q   <= rsp_found_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_hops_q    <= rsp_hops_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_found   = rsp_found_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_hops    = rsp_hops_q;
  assign busy        = (state_q != IDLE);

`ifdef LL_SCHED_STATS_EN
  logic [15:0] stat_searches_q, stat_searches_d;
  logic [15:0] stat_found_q, stat_found_d;
  logic [15:0] stat_timeouts_q, stat_timeouts_d;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q & rsp_ready;

  always_comb begin
    stat_searches_d = stat_searches_q;
    stat_found_d    = stat_found_q;
    stat_timeouts_d = stat_timeouts_q;
    if (stat_clr) begin
      stat_searches_d = '0;
      stat_found_d    = '0;
      stat_timeouts_d = '0;
    end else if (rsp_hs) begin
      if (stat_searches_q != 16'hFFFF) stat_searches_d = stat_searches_q + 16'd1;
      if (rsp_found_q && stat_found_q != 16'hFFFF) stat_found_d = stat_found_q + 16'd1;
      if (rsp_timeout_q && stat_timeouts_q != 16'hFFFF) stat_timeouts_d = stat_timeouts_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_searches_q <= '0;
      stat_found_q    <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_searches_q <= stat_searches_d;
      stat_found_q    <= stat_found_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_searches = stat_searches_q;
  assign stat_found    = stat_found_q;
  assign stat_timeouts = stat_timeouts_q;
`endif
endmodule

// File: tb/tb_ll_search_scheduler.sv
// Bench for ll_search_scheduler: directed scenarios plus randomized traffic against a list-walk model.
// Expected responses are queued at grant time and compared by a monitor when rsp_valid appears.
module tb_ll_search_scheduler;
  localparam int AW = 4, DW = 4, NR = 4, MH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*AW-1:0]  req_start, req_target;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [AW+DW-1:0]  mem_rd_data = '0;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic              rsp_found, rsp_timeout;
  logic [4:0]        rsp_hops;
  logic              busy;
`ifdef LL_SCHED_STATS_EN
  logic              stat_clr = 1'b0;
  logic [15:0]       stat_searches, stat_found, stat_timeouts;
`endif

  ll_search_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_HOPS(MH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_target(req_target),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_found(rsp_found), .rsp_timeout(rsp_timeout), .rsp_hops(rsp_hops),
    .busy(busy)
`ifdef LL_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_searches(stat_searches),
    .stat_found(stat_found), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Node RAM: one-cycle read latency; garbage on the bus when not reading.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    else           mem_rd_data <= 8'($urandom);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference walk straight from the search rules.
  function automatic void ref_walk(input int s, input int t, output int found,
                                   output int tmo, output int hops);
    int c;
    c = s; found = 0; tmo = 0; hops = 0;
    while (1) begin
      if (c == 0) return;
      if (c == t) begin found = 1; return; end
      if (hops == MH) begin tmo = 1; return; end
      c = int'(ram[c][3:0]);
      hops++;
    end
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  typedef struct { int id; int found; int tmo; int hops; int acc; } exp_t;
  typedef struct { int id; int found; int tmo; int hops; int lat; } log_t;
  exp_t exp_q[$];
  log_t rsp_log[$];

  // Monitor state
  int   model_ptr = 0, pick, s_m, f_m, t_m, h_m;
  int   act_curr, act_reads, hs_cnt = 0, fnd_cnt = 0, tmo_cnt = 0;
  logic act = 1'b0, hold = 1'b0, last_rd = 1'b0;
  int   held_id, held_f, held_t, held_h;
  exp_t e;
  log_t l;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_ptr = 0; act = 1'b0; hold = 1'b0; last_rd = 1'b0;
      hs_cnt = 0; fnd_cnt = 0; tmo_cnt = 0;
    end else begin
      check("busy", int'(busy), int'(act));
      pick = act ? -1 : rr_pick(req_valid, model_ptr);
      check("req_ready", int'(req_ready), (pick >= 0) ? (1 << pick) : 0);
      if (pick >= 0) begin
        s_m = int'(req_start[pick*AW +: AW]);
        ref_walk(s_m, int'(req_target[pick*AW +: AW]), f_m, t_m, h_m);
        exp_q.push_back('{id: pick, found: f_m, tmo: t_m, hops: h_m, acc: cyc});
        model_ptr = (pick + 1) % NR;
        act = 1'b1; act_curr = s_m; act_reads = 0;
      end
      if (mem_rd_en) begin
        check("rd_during_search", int'(act), 1);
        check("rd_addr", int'(mem_rd_addr), act_curr);
        check("rd_back_to_back", int'(last_rd), 0);
        act_curr = int'(ram[act_curr][3:0]);
        act_reads++;
      end else begin
        check("rd_addr_idle", int'(mem_rd_addr), 0);
      end
      last_rd = mem_rd_en;
      if (rsp_valid) begin
        if (hold) begin
          check("hold_id", int'(rsp_id), held_id);
          check("hold_found", int'(rsp_found), held_f);
          check("hold_timeout", int'(rsp_timeout), held_t);
          check("hold_hops", int'(rsp_hops), held_h);
        end else begin
          check("rsp_outstanding", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_id", int'(rsp_id), e.id);
            check("rsp_found", int'(rsp_found), e.found);
            check("rsp_timeout", int'(rsp_timeout), e.tmo);
            check("rsp_hops", int'(rsp_hops), e.hops);
            check("rsp_latency", cyc - e.acc, 2 + 2 * e.hops);
            check("rd_count", act_reads, e.hops);
            l = '{id: int'(rsp_id), found: int'(rsp_found), tmo: int'(rsp_timeout),
                  hops: int'(rsp_hops), lat: cyc - e.acc};
            rsp_log.push_back(l);
          end
          held_id = int'(rsp_id); held_f = int'(rsp_found);
          held_t = int'(rsp_timeout); held_h = int'(rsp_hops);
        end
        hold = !rsp_ready;
        if (rsp_ready) begin
          act = 1'b0;
          hs_cnt++; fnd_cnt += int'(rsp_found); tmo_cnt += int'(rsp_timeout);
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Driver
  logic [NR-1:0] pend = '0;
  int            rdy_mode = 0;

  task automatic tick();
    logic [NR-1:0] grab;
    @(negedge clk);
    grab = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (!rst) pend &= ~grab;
    req_valid = pend;
    if (rdy_mode == 0) rsp_ready = 1'b1;
    else if (rdy_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input int i, input int s, input int t);
    pend[i] = 1'b1;
    req_start[i*AW +: AW]  = AW'(s);
    req_target[i*AW +: AW] = AW'(t);
    req_valid = pend;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((pend != 0 || busy || rsp_valid || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", int'(n < budget), 1);
  endtask

  task automatic check_log(input string name, input int idx, input int id, input int found,
                           input int tmo, input int hops, input int lat);
    check({name, "_logged"}, int'(rsp_log.size() > idx), 1);
    if (rsp_log.size() > idx) begin
      check({name, "_id"}, rsp_log[idx].id, id);
      check({name, "_found"}, rsp_log[idx].found, found);
      check({name, "_timeout"}, rsp_log[idx].tmo, tmo);
      check({name, "_hops"}, rsp_log[idx].hops, hops);
      check({name, "_lat"}, rsp_log[idx].lat, lat);
    end
  endtask

  task automatic base_ram();
    for (int a = 0; a < 16; a++) ram[a] = 8'h00;
    ram[3] = 8'hA5; ram[5] = 8'hB9; ram[9] = 8'hC0;
  endtask

  initial begin
    int n, seen;
    rst = 1'b1; req_valid = '0; req_start = '0; req_target = '0; rsp_ready = 1'b0;
    base_ram();
    rdy_mode = 2;
    tick(); tick();
    check("reset_busy", int'(busy), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rd_en", int'(mem_rd_en), 0);
    check("reset_rsp_fields", int'({rsp_id, rsp_found, rsp_timeout, rsp_hops}), 0);
    rst = 1'b0;
    rdy_mode = 0;
    tick();

    // All four requesters at once, then 1 and 3 together.
    rsp_log.delete();
    for (int i = 0; i < NR; i++) issue(i, 3, 3);
    wait_idle(200);
    check("rr4_count", rsp_log.size(), 4);
    for (int i = 0; i < NR; i++) check_log("rr4", i, i, 1, 0, 0, 2);
    rsp_log.delete();
    issue(1, 3, 3); issue(3, 3, 3);
    wait_idle(200);
    check_log("rr13_first", 0, 1, 1, 0, 0, 2);
    check_log("rr13_second", 1, 3, 1, 0, 0, 2);

    // Found after two reads; then walk off the end of the list.
    rsp_log.delete();
    issue(0, 3, 9); wait_idle(200);
    check_log("found9", 0, 0, 1, 0, 2, 6);
    rsp_log.delete();
    issue(2, 3, 7); wait_idle(200);
    check_log("null_end", 0, 2, 0, 0, 3, 8);

    // Cycle 3<->5 forces the hop limit.
    ram[5] = 8'hB3;
    rsp_log.delete();
    issue(1, 3, 7); wait_idle(200);
    check_log("hop_limit", 0, 1, 0, 1, 16, 34);
    base_ram();

    // Start at NULL, then hold the response while another requester waits.
    rsp_log.delete();
    rdy_mode = 2; rsp_ready = 1'b0;
    issue(3, 0, 5);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("null_start_rsp_seen", int'(rsp_valid), 1);
    issue(1, 3, 3);
    repeat (5) begin
      tick();
      check("hold_req_ready", int'(req_ready), 0);
      check("hold_rsp_valid", int'(rsp_valid), 1);
    end
    rsp_ready = 1'b1;
    rdy_mode = 0;
    wait_idle(200);
    check_log("null_start", 0, 3, 0, 0, 0, 2);
    check_log("after_hold", 1, 1, 1, 0, 0, 2);

    // Reset while waiting on read data: the search vanishes.
    issue(0, 3, 9);
    n = 0;
    while (!mem_rd_en && n < 20) begin tick(); n++; end
    check("abort_saw_read", int'(mem_rd_en), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    seen = 0;
    repeat (20) begin tick(); seen += int'(rsp_valid); end
    check("abort_no_rsp", seen, 0);

    // Randomized traffic over random lists.
    for (int r = 0; r < 8; r++) begin
      wait_idle(3000);
      for (int a = 0; a < 16; a++)
        ram[a] = {4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15))};
      rdy_mode = r % 2;
      repeat (80) begin
        tick();
        for (int i = 0; i < NR; i++)
          if (!pend[i] && $urandom_range(0, 3) == 0)
            issue(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)),
                  int'($urandom_range(0, 15)));
      end
      wait_idle(3000);
    end
    rdy_mode = 0;
    tick(); tick();

`ifdef LL_SCHED_STATS_EN
    check("stat_searches", int'(stat_searches), hs_cnt);
    check("stat_found", int'(stat_found), fnd_cnt);
    check("stat_timeouts", int'(stat_timeouts), tmo_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
